// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and registers the returned word.
// Define FETCH_COUNT_EN to add a saturating 32-bit count of fetched instructions.
module instruction_fetch #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int RESET_PC = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              HALT_REQ,
   input  logic              STALL,
   input  logic              REDIRECT,
   input  logic [ADDR_W-1:0] REDIRECT_PC,
   output logic [ADDR_W-1:0] IM_ADDRESS,
   input  logic [DATA_W-1:0] IM_Q,
   output logic [DATA_W-1:0] IR,
   output logic [ADDR_W-1:0] IR_PC,
   output logic              IR_VALID,
   output logic              RUNNING
`ifdef FETCH_COUNT_EN
   ,
   output logic [31:0]       FETCH_COUNT
`endif
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
   logic              ir_valid_q, ir_valid_d;
   logic              advance;

   // Redirect wins over stall so a taken branch is never lost behind a decode stall.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      advance    = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (HALT_REQ) begin
               state_d    = ST_HALTED;
               ir_valid_d = 1'b0;
            end else if (REDIRECT) begin
               pc_d       = REDIRECT_PC;
               ir_valid_d = 1'b0;
            end else if (!STALL) begin
               advance    = 1'b1;
               ir_d       = IM_Q;
               ir_pc_d    = pc_q;
               ir_valid_d = 1'b1;
               pc_d       = pc_q + ADDR_W'(1);
            end
         end
         ST_IDLE, ST_HALTED: begin
            ir_valid_d = 1'b0;
            if (START) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            ir_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC_W;
         ir_q       <= '0;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
      end
   end

`ifdef FETCH_COUNT_EN
   logic [31:0] fetch_count_q, fetch_count_d;

   always_comb begin
      fetch_count_d = fetch_count_q;
      if (advance && (fetch_count_q != 32'hFFFF_FFFF)) begin
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         fetch_count_q <= '0;
      end else begin
         fetch_count_q <= fetch_count_d;
      end
   end

   assign FETCH_COUNT = fetch_count_q;
`else
   logic unused_advance;
   assign unused_advance = advance;
`endif

   assign IM_ADDRESS = pc_q;
   assign IR         = ir_q;
   assign IR_PC      = ir_pc_q;
   assign IR_VALID   = ir_valid_q;
   assign RUNNING    = (state_q == ST_RUN);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random control traffic,
// every cycle compared against a behavioural model of the fetch stage.
module tb_instruction_fetch;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              CLK = 1'b0;
   logic              RST;
   logic              START;
   logic              HALT_REQ;
   logic              STALL;
   logic              REDIRECT;
   logic [ADDR_W-1:0] REDIRECT_PC;
   logic [ADDR_W-1:0] IM_ADDRESS;
   logic [DATA_W-1:0] IM_Q;
   logic [DATA_W-1:0] IR;
   logic [ADDR_W-1:0] IR_PC;
   logic              IR_VALID;
   logic              RUNNING;
`ifdef FETCH_COUNT_EN
   logic [31:0]       FETCH_COUNT;
`endif

   logic [DATA_W-1:0] mem [DEPTH];

   int checkCount = 0;
   int passCount  = 0;

   // Reference model: running flag, PC, IR contents and fetch count.
   bit                mRun;
   int                mPc;
   logic [DATA_W-1:0] mIr;
   int                mIrPc;
   bit                mValid;
   longint            mCount;

   instruction_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
      .CLK(CLK),
      .RST(RST),
      .START(START),
      .HALT_REQ(HALT_REQ),
      .STALL(STALL),
      .REDIRECT(REDIRECT),
      .REDIRECT_PC(REDIRECT_PC),
      .IM_ADDRESS(IM_ADDRESS),
      .IM_Q(IM_Q),
      .IR(IR),
      .IR_PC(IR_PC),
      .IR_VALID(IR_VALID),
      .RUNNING(RUNNING)
`ifdef FETCH_COUNT_EN
      ,
      .FETCH_COUNT(FETCH_COUNT)
`endif
   );

   assign IM_Q = mem[IM_ADDRESS];

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
      end else begin
         passCount++;
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit start, input bit halt, input bit stall,
                                input bit redir, input int rpc);
      RST         = rst;
      START       = start;
      HALT_REQ    = halt;
      STALL       = stall;
      REDIRECT    = redir;
      REDIRECT_PC = ADDR_W'(rpc);
   endtask

   task automatic modelStep();
      if (RST) begin
         mRun = 0; mPc = 0; mIr = '0; mIrPc = 0; mValid = 0; mCount = 0;
      end else if (!mRun) begin
         mValid = 0;
         if (START) mRun = 1;
      end else if (HALT_REQ) begin
         mRun   = 0;
         mValid = 0;
      end else if (REDIRECT) begin
         mPc    = int'(REDIRECT_PC);
         mValid = 0;
      end else if (!STALL) begin
         mIr    = mem[mPc];
         mIrPc  = mPc;
         mValid = 1;
         mPc    = (mPc + 1) % DEPTH;
         if (mCount < 64'hFFFF_FFFF) mCount++;
      end
   endtask

   task automatic checkModel();
      checkOutput("im_address", 32'(IM_ADDRESS), 32'(mPc));
      checkOutput("ir_valid", 32'(IR_VALID), 32'(mValid));
      checkOutput("running", 32'(RUNNING), 32'(mRun));
      checkOutput("ir", IR, mIr);
      checkOutput("ir_pc", 32'(IR_PC), 32'(mIrPc));
`ifdef FETCH_COUNT_EN
      checkOutput("fetch_count", FETCH_COUNT, mCount[31:0]);
`endif
   endtask

   task automatic tick();
      @(posedge CLK);
      modelStep();
      #1;
      checkModel();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      applyStimulus(1, 0, 0, 0, 0, 0);

      // Reset, then start: IR walks mem[0..3] from two cycles after START.
      tick();
      checkOutput("reset_ir_valid", 32'(IR_VALID), 32'd0);
      checkOutput("reset_pc", 32'(IM_ADDRESS), 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("idle_running", 32'(RUNNING), 32'd0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      tick();
      checkOutput("start_running", 32'(RUNNING), 32'd1);
      checkOutput("start_ir_valid", 32'(IR_VALID), 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         checkOutput("seq_ir", IR, mem[k]);
         checkOutput("seq_ir_pc", 32'(IR_PC), 32'(k));
         checkOutput("seq_ir_valid", 32'(IR_VALID), 32'd1);
      end

      // Stall at PC=5 holds everything, release fetches mem[5].
      tick();
      applyStimulus(0, 0, 0, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("stall_addr", 32'(IM_ADDRESS), 32'd5);
         checkOutput("stall_ir_pc", 32'(IR_PC), 32'd4);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("unstall_ir", IR, mem[5]);
      checkOutput("unstall_ir_pc", 32'(IR_PC), 32'd5);

      // Redirect during stall squashes and retargets.
      applyStimulus(0, 0, 0, 1, 1, 'h200);
      tick();
      checkOutput("redir_valid", 32'(IR_VALID), 32'd0);
      checkOutput("redir_addr", 32'(IM_ADDRESS), 32'h200);
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("redir_ir", IR, mem['h200]);
      checkOutput("redir_ir_pc", 32'(IR_PC), 32'h200);

      // Wrap from 0x3FF to 0x000 without a bubble.
      applyStimulus(0, 0, 0, 0, 1, 'h3FF);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("wrap_ir_pc_hi", 32'(IR_PC), 32'h3FF);
      tick();
      checkOutput("wrap_ir_pc_lo", 32'(IR_PC), 32'h000);
      checkOutput("wrap_valid", 32'(IR_VALID), 32'd1);

      // Halt at PC=7, control inputs ignored while halted, resume at 7.
      applyStimulus(0, 0, 0, 0, 1, 7);
      tick();
      applyStimulus(0, 0, 1, 0, 0, 0);
      tick();
      checkOutput("halt_running", 32'(RUNNING), 32'd0);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
         tick();
         checkOutput("halt_addr", 32'(IM_ADDRESS), 32'd7);
      end
      applyStimulus(0, 1, 1, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("resume_ir_pc", 32'(IR_PC), 32'd7);

      // Reset mid-run overrides a stall.
      applyStimulus(0, 0, 0, 0, 1, 'h123);
      tick();
      applyStimulus(1, 0, 0, 1, 0, 0);
      tick();
      checkOutput("rst_addr", 32'(IM_ADDRESS), 32'd0);
      checkOutput("rst_ir", IR, 32'd0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("refetch_ir", IR, mem[0]);

      // Random control traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 9) == 0, $urandom);
         tick();
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
